// File: rtl/fnd_scan_controller.sv
// Multiplexed common-anode 7-segment scanner with per-frame input snapshot,
// leading-zero blanking, per-digit blink/dp and 16-level PWM brightness.

module fnd_digit_font (
   input  logic [3:0] nibble,
   input  logic       lz_blank,
   input  logic       blink_blank,
   input  logic       dot,
   output logic [7:0] font
);
   logic [6:0] seg;

   always_comb begin
      case (nibble)
         4'h0: seg = 7'h40;
         4'h1: seg = 7'h79;
         4'h2: seg = 7'h24;
         4'h3: seg = 7'h30;
         4'h4: seg = 7'h19;
         4'h5: seg = 7'h12;
         4'h6: seg = 7'h02;
         4'h7: seg = 7'h78;
         4'h8: seg = 7'h00;
         4'h9: seg = 7'h10;
         4'hA: seg = 7'h08;
         4'hB: seg = 7'h03;
         4'hC: seg = 7'h46;
         4'hD: seg = 7'h21;
         4'hE: seg = 7'h06;
         default: seg = 7'h0E;
      endcase
      // a blanked digit keeps its dp unless the blink also hides it
      font = {~dot | blink_blank, (lz_blank | blink_blank) ? 7'h7F : seg};
   end
endmodule

module fnd_scan_controller #(
   parameter int NUM_DIGITS   = 4,
   parameter int SUB_DIV      = 6250,
   parameter int BLINK_FRAMES = 125
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [4*NUM_DIGITS-1:0] digits,
   input  logic [NUM_DIGITS-1:0]   dot_mask,
   input  logic [NUM_DIGITS-1:0]   blink_mask,
   input  logic                    lzb_en,
   input  logic [3:0]              brightness,
   output logic [7:0]              fnd_font,
   output logic [NUM_DIGITS-1:0]   fnd_comm,
   output logic                    frame_start
);
   localparam int PW = (SUB_DIV > 1) ? $clog2(SUB_DIV) : 1;
   localparam int IW = $clog2(NUM_DIGITS);
   localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

   typedef struct packed {
      logic [NUM_DIGITS-1:0][3:0] dig;
      logic [NUM_DIGITS-1:0]      dot;
      logic [NUM_DIGITS-1:0]      blink;
      logic                       lzb;
      logic [3:0]                 bright;
   } snap_t;

   snap_t                       snap;
   logic [PW-1:0]               pre;
   logic [3:0]                  sub;
   logic [IW-1:0]               idx;
   logic [FW-1:0]               fcnt;
   logic                        phase;
   logic                        sub_tick;
   logic                        take_snap;
   logic                        lit;
   logic                        zero_run;
   logic [NUM_DIGITS-1:0]       lz_blank;
   logic [NUM_DIGITS-1:0][7:0]  slot_font;

   assign sub_tick  = (pre == PW'(SUB_DIV - 1));
   assign take_snap = sub_tick && (sub == 4'd0) && (idx == '0);
   assign lit       = (sub != 4'd0) && (sub <= snap.bright);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pre <= '0;
         sub <= '0;
         idx <= '0;
      end else begin
         pre <= sub_tick ? '0 : pre + 1'b1;
         if (sub_tick) begin
            sub <= sub + 1'b1;
            if (sub == 4'hF)
               idx <= (idx == IW'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;
         end
      end
   end

   // snapshot once per frame, at the first lit sub-tick of digit 0
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         snap        <= '0;
         fcnt        <= '0;
         phase       <= 1'b0;
         frame_start <= 1'b0;
      end else begin
         frame_start <= take_snap;
         if (take_snap) begin
            snap <= {digits, dot_mask, blink_mask, lzb_en, brightness};
            if (fcnt == FW'(BLINK_FRAMES - 1)) begin
               fcnt  <= '0;
               phase <= ~phase;
            end else begin
               fcnt <= fcnt + 1'b1;
            end
         end
      end
   end

   always_comb begin
      lz_blank = '0;
      zero_run = snap.lzb;
      for (int i = NUM_DIGITS - 1; i > 0; i--) begin
         zero_run    = zero_run && (snap.dig[i] == 4'd0);
         lz_blank[i] = zero_run;
      end
   end

   for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dig
      fnd_digit_font u_font (
         .nibble      (snap.dig[g]),
         .lz_blank    (lz_blank[g]),
         .blink_blank (phase & snap.blink[g]),
         .dot         (snap.dot[g]),
         .font        (slot_font[g])
      );
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fnd_font <= 8'hFF;
         fnd_comm <= '1;
      end else if (lit) begin
         fnd_font <= slot_font[idx];
         fnd_comm <= ~(NUM_DIGITS'(1) << idx);
      end else begin
         fnd_font <= 8'hFF;
         fnd_comm <= '1;
      end
   end
endmodule

// File: tb/tb_fnd_scan_controller.sv
// Scoreboard bench: a cycle-count reference predicts each lit slot per frame;
// a monitor reassembles lit runs from the pins and compares them.

module tb_fnd_scan_controller;
   localparam int ND    = 4;
   localparam int SD    = 4;
   localparam int BF    = 2;
   localparam int FRAME = ND * 16 * SD;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] digits;
   logic [3:0]  dot_mask, blink_mask, brightness;
   logic        lzb_en;
   logic [7:0]  fnd_font;
   logic [3:0]  fnd_comm;
   logic        frame_start;

   always #5 clk = ~clk;

   fnd_scan_controller #(.NUM_DIGITS(ND), .SUB_DIV(SD), .BLINK_FRAMES(BF)) dut (
      .clk(clk), .rst(rst), .digits(digits), .dot_mask(dot_mask),
      .blink_mask(blink_mask), .lzb_en(lzb_en), .brightness(brightness),
      .fnd_font(fnd_font), .fnd_comm(fnd_comm), .frame_start(frame_start)
   );

   typedef struct {
      int         idx;
      logic [7:0] font;
      int         len;
   } exp_t;

   exp_t       q[$];
   int         checks = 0;
   int         errors = 0;
   int         ecnt = 0;
   int         bcnt = 0;
   bit         phase = 0;
   logic [6:0] font_tab [0:15];

   initial font_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

   // reference: edge count since reset release gives the scan position
   bit   zero_up, lzb_b, bb;
   exp_t ex;
   initial forever begin
      @(posedge clk);
      if (!rst) begin
         ecnt = 0; bcnt = 0; phase = 0;
         q.delete();
      end else begin
         ecnt++;
         if (ecnt % FRAME == 4) begin
            bcnt++;
            if (bcnt == BF) begin bcnt = 0; phase = ~phase; end
            if (brightness != 0) begin
               for (int i = 0; i < ND; i++) begin
                  zero_up = 1;
                  for (int j = i; j < ND; j++) if (digits[4*j +: 4] != 4'd0) zero_up = 0;
                  lzb_b  = lzb_en && (i > 0) && zero_up;
                  bb     = phase && blink_mask[i];
                  ex.idx = i;
                  ex.len = SD * int'(brightness);
                  ex.font = {bb | ~dot_mask[i], (lzb_b || bb) ? 7'h7F : font_tab[digits[4*i +: 4]]};
                  q.push_back(ex);
               end
            end
         end
      end
   end

   bit         in_run = 0;
   logic [3:0] run_comm, want_comm;
   logic [7:0] run_font;
   int         run_len;
   exp_t       got;

   task automatic finish_run();
      in_run = 0;
      checks++;
      if (q.size() == 0) begin
         errors++;
         $display("FAIL unexpected_lit: comm=%h font=%h len=%0d, want no lit slot", run_comm, run_font, run_len);
      end else begin
         got = q.pop_front();
         want_comm = ~(4'b0001 << got.idx);
         if (run_comm != want_comm || run_font != got.font || run_len != got.len) begin
            errors++;
            $display("FAIL slot: comm=%h font=%h len=%0d, want comm=%h font=%h len=%0d",
                     run_comm, run_font, run_len, want_comm, got.font, got.len);
         end
      end
   endtask

   initial forever begin
      @(negedge clk);
      if (!rst) begin
         in_run = 0;
         checks++;
         if (fnd_comm !== 4'hF || fnd_font !== 8'hFF || frame_start !== 1'b0) begin
            errors++;
            $display("FAIL reset_dark: comm=%h font=%h fs=%b, want F FF 0", fnd_comm, fnd_font, frame_start);
         end
      end else begin
         checks++;
         if (frame_start !== (ecnt % FRAME == 4)) begin
            errors++;
            $display("FAIL frame_start: got %b at edge %0d, want %b", frame_start, ecnt, ecnt % FRAME == 4);
         end
         checks++;
         if (!((fnd_comm == 4'hF && fnd_font == 8'hFF) || (fnd_comm != 4'hF && $countones(~fnd_comm) == 1))) begin
            errors++;
            $display("FAIL one_hot: comm=%h font=%h, want one low bit or F/FF", fnd_comm, fnd_font);
         end
         if (in_run && (fnd_comm != run_comm || fnd_font != run_font)) finish_run();
         if (fnd_comm != 4'hF) begin
            if (!in_run) begin
               in_run = 1; run_comm = fnd_comm; run_font = fnd_font; run_len = 0;
            end
            run_len++;
         end
      end
   end

   task automatic set_in(input logic [15:0] d, input logic [3:0] dm, input logic [3:0] bm,
                         input logic lz, input logic [3:0] br);
      digits = d; dot_mask = dm; blink_mask = bm; lzb_en = lz; brightness = br;
   endtask

   task automatic frames(input int n);
      repeat (n * FRAME) @(negedge clk);
   endtask

   task automatic drain();
      int n = 0;
      while (ecnt % FRAME != 3 && n < 2 * FRAME) begin @(negedge clk); n++; end
      checks++;
      if (q.size() != 0 || ecnt % FRAME != 3) begin
         errors++;
         $display("FAIL drain: %0d slots pending at edge %0d, want 0 at frame end", q.size(), ecnt);
      end
   endtask

   initial begin
      rst = 1'b0;
      set_in(16'h0, 4'h0, 4'h0, 1'b0, 4'h0);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      set_in(16'h12A9, 4'h0, 4'h0, 1'b0, 4'd15); frames(3);
      set_in(16'h0050, 4'h0, 4'h0, 1'b1, 4'd15); frames(2);
      set_in(16'h0000, 4'h0, 4'h0, 1'b1, 4'd15); frames(2);
      set_in(16'h12A9, 4'h0, 4'h0, 1'b0, 4'd4);  frames(2);
      set_in(16'h12A9, 4'h0, 4'h0, 1'b0, 4'd0);  frames(2);
      set_in(16'h0000, 4'h1, 4'h1, 1'b0, 4'd15); frames(6);
      for (int c = 0; c < 20 * FRAME; c++) begin
         @(negedge clk);
         if ($urandom_range(0, 39) == 0)
            set_in(16'($urandom_range(0, 65535) >> (4 * $urandom_range(0, 4))),
                   4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                   1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
      end
      drain();
      set_in(16'h12A9, 4'h0, 4'h0, 1'b0, 4'd15);
      repeat (97) @(negedge clk);
      @(posedge clk);
      #1 rst = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      set_in(16'h0050, 4'h2, 4'h0, 1'b1, 4'd9); frames(2);
      drain();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
